// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, 3-sample majority per bit,
// start-glitch rejection, parity/framing/overrun flags and break handling.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 20,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    input  logic                 reset_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_EVAL = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_reg;
    logic [CW-1:0]          cnt_reg;
    logic [BW-1:0]          bit_idx_reg;
    logic                   stop_idx_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   s0_reg;
    logic                   s1_reg;
    logic                   par_bad_reg;
    logic                   frame_bad_reg;

    logic                   rx_meta_reg;
    logic                   rxs;
    logic                   rxs_prev_reg;
    logic [1:0]             sync_valid_reg;

    logic                   fall;
    logic                   maj;
    logic                   par_bad_next;
    logic                   frame_bad_next;

    // Edge detection is held off until the synchroniser carries real line
    // samples, so a line already low when reset releases is never a start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg    <= 1'b1;
            rxs            <= 1'b1;
            rxs_prev_reg   <= 1'b0;
            sync_valid_reg <= 2'b00;
        end else begin
            rx_meta_reg    <= rx_i;
            rxs            <= rx_meta_reg;
            rxs_prev_reg   <= sync_valid_reg[1] ? rxs : 1'b0;
            sync_valid_reg <= {sync_valid_reg[0], 1'b1};
        end
    end

    assign fall           = sync_valid_reg[1] & rxs_prev_reg & ~rxs;
    assign maj            = (s0_reg & s1_reg) | (s0_reg & rxs) | (s1_reg & rxs);
    assign par_bad_next   = maj ^ (^shift_reg) ^ PAR_ODD;
    assign frame_bad_next = frame_bad_reg | ~maj;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            stop_idx_reg  <= 1'b0;
            shift_reg     <= '0;
            s0_reg        <= 1'b0;
            s1_reg        <= 1'b0;
            par_bad_reg   <= 1'b0;
            frame_bad_reg <= 1'b0;
            data          <= '0;
            ready         <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            if (reset_ready && ready) begin
                ready      <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end

            if (state_reg != S_IDLE)
                cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
            if (cnt_reg == CNT_S0)
                s0_reg <= rxs;
            if (cnt_reg == CNT_S1)
                s1_reg <= rxs;

            case (state_reg)
                S_IDLE: begin
                    cnt_reg       <= '0;
                    bit_idx_reg   <= '0;
                    stop_idx_reg  <= 1'b0;
                    par_bad_reg   <= 1'b0;
                    frame_bad_reg <= 1'b0;
                    if (fall) begin
                        state_reg <= S_START;
                        busy      <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_reg == CNT_EVAL && maj) begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_reg == CNT_EVAL)
                        shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
                    if (cnt_reg == CNT_LAST) begin
                        if (bit_idx_reg == BIT_LAST)
                            state_reg <= (PARITY == 0) ? S_STOP : S_PARITY;
                        else
                            bit_idx_reg <= bit_idx_reg + BW'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt_reg == CNT_EVAL)
                        par_bad_reg <= par_bad_next;
                    if (cnt_reg == CNT_LAST)
                        state_reg <= S_STOP;
                end
                S_STOP: begin
                    if (cnt_reg == CNT_EVAL) begin
                        if (stop_idx_reg == STOP_LAST) begin
                            // Completion wins over a same-cycle acknowledge.
                            if (!ready || reset_ready) begin
                                data       <= shift_reg;
                                ready      <= 1'b1;
                                parity_err <= par_bad_reg;
                                frame_err  <= frame_bad_next;
                                overrun    <= overrun;
                            end else begin
                                overrun    <= 1'b1;
                            end
                            cnt_reg <= '0;
                            if (frame_bad_next) begin
                                state_reg <= S_BREAK;
                            end else begin
                                state_reg <= S_IDLE;
                                busy      <= 1'b0;
                            end
                        end else begin
                            frame_bad_reg <= frame_bad_next;
                            stop_idx_reg  <= 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    cnt_reg <= '0;
                    if (rxs) begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: a default instance (8E1, 20 clk/bit)
// and a 7O2 instance at 16 clk/bit, each on its own serial line.
`timescale 1ns/1ps
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a, rx_b;
    logic       rr_a, rr_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       ready_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       ready_b, perr_b, ferr_b, ovr_b, busy_b;

    int      total = 0;
    int      bad   = 0;
    int      rdy_cnt_a = 0;
    int      rdy_cnt_b = 0;
    realtime t_rdy_a = 0.0;
    realtime t_start = 0.0;

    always #10 clk = ~clk;

    uart_rx_param #(
        .CLKS_PER_BIT(20), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .reset(reset), .rx_i(rx_a), .data(data_a), .ready(ready_a),
        .reset_ready(rr_a), .parity_err(perr_a), .frame_err(ferr_a),
        .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_param #(
        .CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .reset(reset), .rx_i(rx_b), .data(data_b), .ready(ready_b),
        .reset_ready(rr_b), .parity_err(perr_b), .frame_err(ferr_b),
        .overrun(ovr_b), .busy(busy_b)
    );

    always @(posedge ready_a) begin
        rdy_cnt_a++;
        t_rdy_a = $realtime;
    end

    always @(posedge ready_b) rdy_cnt_b++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic drive_bit(input int sel, input logic v, input int bns);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
        #(bns);
    endtask

    // Start, nb data bits LSB first, optional parity bit, ns stop bits of sval.
    task automatic send_frame(input int sel, input logic [8:0] d, input int nb,
                              input int has_par, input logic pbit, input int ns,
                              input logic sval, input int bns);
        @(negedge clk);
        t_start = $realtime;
        drive_bit(sel, 1'b0, bns);
        for (int i = 0; i < nb; i++) drive_bit(sel, d[i], bns);
        if (has_par != 0) drive_bit(sel, pbit, bns);
        for (int i = 0; i < ns; i++) drive_bit(sel, sval, bns);
        $display("frame line=%0d data=0x%0h par=%0b stop=%0b", sel, d, pbit, sval);
    endtask

    task automatic ack(input int sel);
        @(negedge clk);
        if (sel == 0) rr_a = 1'b1;
        else          rr_b = 1'b1;
        @(negedge clk);
        rr_a = 1'b0;
        rr_b = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        reset = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rr_a  = 1'b0;
        rr_b  = 1'b0;
        #5 reset = 1'b0;
        #100;
        chk("rst_data_a",  32'(data_a),  0);
        chk("rst_ready_a", 32'(ready_a), 0);
        chk("rst_perr_a",  32'(perr_a),  0);
        chk("rst_ferr_a",  32'(ferr_a),  0);
        chk("rst_ovr_a",   32'(ovr_a),   0);
        chk("rst_busy_a",  32'(busy_a),  0);
        chk("rst_ready_b", 32'(ready_b), 0);
        @(negedge clk) reset = 1'b1;
        repeat (10) @(negedge clk);

        // Clean 0x1D with correct even parity
        send_frame(0, 9'h01D, 8, 1, 1'b0, 1, 1'b1, 400);
        chk("t1_data",  32'(data_a),  32'h1D);
        chk("t1_ready", 32'(ready_a), 1);
        chk("t1_perr",  32'(perr_a),  0);
        chk("t1_ferr",  32'(ferr_a),  0);
        chk("t1_ovr",   32'(ovr_a),   0);
        lat = int'(t_rdy_a - t_start);
        $display("latency start-edge to ready = %0d ns", lat);
        chk("t1_latency_in_4200_4340", 32'((lat >= 4200 && lat <= 4340) ? 1 : 0), 1);
        ack(0);
        chk("t1_ack_ready", 32'(ready_a), 0);

        // Wrong parity bit
        send_frame(0, 9'h01D, 8, 1, 1'b1, 1, 1'b1, 400);
        chk("t2_data",  32'(data_a),  32'h1D);
        chk("t2_ready", 32'(ready_a), 1);
        chk("t2_perr",  32'(perr_a),  1);
        ack(0);
        chk("t2_ack_ready", 32'(ready_a), 0);
        chk("t2_ack_perr",  32'(perr_a),  0);

        // Overrun: second word dropped
        send_frame(0, 9'h01D, 8, 1, 1'b0, 1, 1'b1, 400);
        send_frame(0, 9'h0A5, 8, 1, 1'b0, 1, 1'b1, 400);
        chk("t3_data",  32'(data_a),  32'h1D);
        chk("t3_ovr",   32'(ovr_a),   1);
        chk("t3_ready", 32'(ready_a), 1);
        chk("t3_perr",  32'(perr_a),  0);
        ack(0);
        chk("t3_ack_ovr",   32'(ovr_a),   0);
        chk("t3_ack_ready", 32'(ready_a), 0);

        // 60 ns glitch on idle line
        @(negedge clk);
        n = rdy_cnt_a;
        rx_a = 1'b0;
        #60;
        rx_a = 1'b1;
        #60;
        chk("t4_busy_during_glitch", 32'(busy_a), 1);
        #400;
        chk("t4_busy_after_glitch", 32'(busy_a), 0);
        chk("t4_ready_after_glitch", 32'(rdy_cnt_a - n), 0);
        send_frame(0, 9'h03C, 8, 1, 1'b0, 1, 1'b1, 400);
        chk("t4_data",  32'(data_a),  32'h3C);
        chk("t4_ready", 32'(ready_a), 1);
        chk("t4_perr",  32'(perr_a),  0);
        ack(0);

        // Break: 0x00 with low stop bit, then line held low
        n = rdy_cnt_a;
        send_frame(0, 9'h000, 8, 1, 1'b0, 1, 1'b0, 400);
        #2000;
        chk("t5_ready",     32'(ready_a), 1);
        chk("t5_ferr",      32'(ferr_a),  1);
        chk("t5_data",      32'(data_a),  32'h00);
        chk("t5_one_ready", 32'(rdy_cnt_a - n), 1);
        chk("t5_busy_held", 32'(busy_a),  1);
        rx_a = 1'b1;
        #400;
        chk("t5_busy_released", 32'(busy_a), 0);
        ack(0);
        chk("t5_ack_ferr", 32'(ferr_a), 0);
        send_frame(0, 9'h081, 8, 1, 1'b0, 1, 1'b1, 400);
        chk("t5_next_data",  32'(data_a),  32'h81);
        chk("t5_next_ferr",  32'(ferr_a),  0);
        chk("t5_next_ready", 32'(ready_a), 1);
        ack(0);

        // 7 data bits, odd parity, two stop bits
        send_frame(1, 9'h055, 7, 1, 1'b1, 2, 1'b1, 320);
        chk("b_data",  32'(data_b),  32'h55);
        chk("b_ready", 32'(ready_b), 1);
        chk("b_perr",  32'(perr_b),  0);
        chk("b_ferr",  32'(ferr_b),  0);
        chk("b_ovr",   32'(ovr_b),   0);

        // Reset in the middle of the data bits
        @(negedge clk);
        n = rdy_cnt_b;
        drive_bit(1, 1'b0, 320);
        drive_bit(1, 1'b1, 320);
        drive_bit(1, 1'b0, 320);
        drive_bit(1, 1'b1, 320);
        rx_b = 1'b0;
        #160;
        reset = 1'b0;
        #1;
        chk("b_rst_data",  32'(data_b),  0);
        chk("b_rst_ready", 32'(ready_b), 0);
        chk("b_rst_busy",  32'(busy_b),  0);
        chk("b_rst_perr",  32'(perr_b),  0);
        chk("b_rst_ferr",  32'(ferr_b),  0);
        chk("b_rst_ovr",   32'(ovr_b),   0);
        @(negedge clk) reset = 1'b1;
        #200;
        chk("b_low_after_release_busy", 32'(busy_b), 0);
        rx_b = 1'b1;
        #4000;
        chk("b_abort_no_ready", 32'(rdy_cnt_b - n), 0);
        chk("b_abort_busy",     32'(busy_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8-bit UART receiver used in the host link.
- Configurable clocks-per-bit, data width, parity mode and stop-bit count.
- Adds an input synchroniser, 3-sample majority voting, start-bit glitch rejection, parity/framing/overrun error flags and break handling.
- Sits between the board RX pin and the command parser; delivers one word per frame through the existing ready/reset_ready handshake.

Parameters:
- CLKS_PER_BIT, 20, clk cycles per bit; minimum 8. Default gives a 400 ns bit at a 20 ns clk.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY, 1, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset = 0 resets).
- rx_i  input  1  serial line; idles high; asynchronous to clk.
- data  output  DATA_BITS  last received word.
- ready  output  1  high while data holds an unconsumed word.
- reset_ready  input  1  consumer acknowledge; sampled high on a clk edge, it clears ready.
- parity_err  output  1  parity mismatch on the word in data.
- frame_err  output  1  a stop bit sampled low on the word in data.
- overrun  output  1  a frame completed while ready was still high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, data = 0, ready = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0, synchroniser flops = 1, all counters = 0.
- Synchroniser: two flops on rx_i; all logic uses the second flop (rxs). This adds 2 cycles of input latency.
- Bit timing: counter cnt runs 0..CLKS_PER_BIT-1, then wraps. Samples are taken at cnt = H-1, H and H+1, where H = CLKS_PER_BIT/2. The bit value is the 2-of-3 majority, evaluated at cnt = H+1.
- States:
  - IDLE: a falling edge on rxs goes to START with cnt = 0.
  - START: if the majority is 1 (glitch), return to IDLE. At the end of the bit period go to DATA.
  - DATA: shift the majority into a shift register, LSB first. After DATA_BITS bits go to PARITY, or to STOP if PARITY = 0.
  - PARITY: compare the majority with the XOR of the data bits (even), or its inverse (odd). At the end of the bit period go to STOP.
  - STOP: sample STOP_BITS bits. Any stop bit with majority 0 sets a frame error. Evaluation of the final stop bit's majority completes the frame.
- Frame complete, cycle after the final-stop-bit evaluation:
  - If ready = 0, or reset_ready is high in that same cycle: load data, parity_err and frame_err; set ready = 1; leave overrun unchanged.
  - Otherwise: drop the new word, keep data and its error flags, set overrun = 1.
- After completion:
  - No frame error: return to IDLE immediately. A new start bit may begin at the next falling edge.
  - Frame error: go to BREAK and wait for rxs = 1 before IDLE, so a held-low line yields exactly one frame.
- Handshake:
  - reset_ready high on an edge with ready = 1 clears ready, parity_err, frame_err and overrun on the next cycle. Completion in the same cycle takes priority, as stated above.
  - reset_ready high while ready = 0 has no effect.
  - reset_ready may be held high continuously; every frame then delivers a one-cycle ready pulse.
- Total latency: ready rises 3 cycles after the mid-point (cnt = H+1) of the last stop bit: 2 synchroniser cycles plus 1 register cycle.
- Reset mid-frame: the frame is aborted and nothing is delivered. After release, a low rx_i is not treated as a start until a falling edge is seen.
- busy = 1 in START, DATA, PARITY, STOP and BREAK.

Test Plan:
- Defaults, clk 20 ns. Send start, bits 1,0,1,1,1,0,0,0, parity 0, stop 1 at 400 ns/bit -> data = 0x1D; ready = 1 about 4260 ns after the start edge; parity_err = 0, frame_err = 0, overrun = 0.
- Same frame with parity bit 1 -> data = 0x1D, ready = 1, parity_err = 1. Then pulse reset_ready for 1 cycle -> ready = 0 and parity_err = 0 on the next cycle.
- Send 0x1D, do not acknowledge, send 0xA5 -> data stays 0x1D, overrun = 1.
- Drive a 60 ns low glitch on idle rx_i -> busy returns to 0 within one bit time; ready stays 0. Then send 0x3C -> data = 0x3C.
- Send 0x00 with the stop bit low, then hold rx low for 2000 ns -> frame_err = 1, exactly one ready. The next frame (0x81) is received only after rx returns high.
- Instantiate DATA_BITS = 7, PARITY = 2, STOP_BITS = 2, CLKS_PER_BIT = 16 and send 0x55 -> data = 0x55, no errors. Assert reset mid-data on a second frame -> all outputs 0 immediately and no ready.
